// File: rtl/gauss_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gauss_frame_ctrl
//  Purpose  : Frame sequencer for a 3x3 Gaussian filter unit. Walks every
//             pixel of an IMG_W x IMG_H 8-bit image in a synchronous-read
//             source memory. For each pixel it gathers the clamped 3x3
//             neighbourhood and drives the filter. When the filter reports
//             done, the result goes to the destination memory at the same
//             address. A one-cycle frame_done_o pulse follows the last write.
//  Ports    : clk_i_g / rst_i_g        clock, synchronous active-high reset
//             start_i                  frame start (ignored while busy_o)
//             busy_o, frame_done_o     frame status
//             rd_en_o/rd_addr_o/rd_data_i   source memory (1-cycle latency)
//             g_en_o/g_win_o/g_data_i/g_done_i  filter unit interface
//             wr_en_o/wr_addr_o/wr_data_o   destination memory
//  Options  : GAUSS_BORDER_CLAMP_EN defined   -> border pixels are filtered
//                                               with a clamped window.
//             GAUSS_BORDER_CLAMP_EN undefined -> border pixels bypass the
//                                               filter (raw centre copied).
//  Revision : 1.0  initial release
// ============================================================================
module gauss_frame_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 16
) (
    input  logic          clk_i_g,
    input  logic          rst_i_g,
    input  logic          start_i,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [7:0]    rd_data_i,
    output logic          g_en_o,
    output logic [71:0]   g_win_o,
    input  logic [7:0]    g_data_i,
    input  logic          g_done_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_NEXT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [3:0]    r_cnt;      // FETCH cycle counter: read k issued when r_cnt == k
    logic [71:0]   r_win;
    logic [7:0]    r_result;

    logic          w_last_x;
    logic          w_last_y;
    logic          w_bypass;
    logic          w_fetch_done;
    logic [3:0]    w_k;
    logic [XW-1:0] w_xc;
    logic [YW-1:0] w_yc;
    logic [AW-1:0] w_rd_addr;
    logic [AW-1:0] w_wr_addr;

    assign w_last_x = (r_x == XW'(IMG_W - 1));
    assign w_last_y = (r_y == YW'(IMG_H - 1));

`ifdef GAUSS_BORDER_CLAMP_EN
    assign w_bypass = 1'b0;
`else
    assign w_bypass = (r_x == '0) || w_last_x || (r_y == '0) || w_last_y;
`endif

    // Bypassed pixels need only the centre read, so the fetch is 2 cycles.
    assign w_fetch_done = w_bypass ? (r_cnt == 4'd1) : (r_cnt == 4'd9);
    assign w_k          = w_bypass ? 4'd4 : r_cnt;

    // Neighbour coordinate, clamped to the image edge.
    always_comb begin
        w_xc = r_x;
        w_yc = r_y;
        if (w_k == 4'd0 || w_k == 4'd3 || w_k == 4'd6) begin
            if (r_x != '0) w_xc = r_x - XW'(1);
        end else if (w_k == 4'd2 || w_k == 4'd5 || w_k == 4'd8) begin
            if (!w_last_x) w_xc = r_x + XW'(1);
        end
        if (w_k <= 4'd2) begin
            if (r_y != '0) w_yc = r_y - YW'(1);
        end else if (w_k >= 4'd6) begin
            if (!w_last_y) w_yc = r_y + YW'(1);
        end
    end

    assign w_rd_addr = AW'(w_yc) * AW'(IMG_W) + AW'(w_xc);
    assign w_wr_addr = AW'(r_y) * AW'(IMG_W) + AW'(r_x);

    always_ff @(posedge clk_i_g) begin
        if (rst_i_g) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state and outputs. Reset forces every output low in the same cycle.
    always_comb begin
        w_next       = r_state;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        rd_en_o      = 1'b0;
        rd_addr_o    = '0;
        g_en_o       = 1'b0;
        g_win_o      = r_win;
        wr_en_o      = 1'b0;
        wr_addr_o    = '0;
        wr_data_o    = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next = S_FETCH;
            end
            S_FETCH: begin
                busy_o = 1'b1;
                if (w_fetch_done) begin
                    w_next = w_bypass ? S_WRITE : S_RUN;
                end else begin
                    rd_en_o   = 1'b1;
                    rd_addr_o = w_rd_addr;
                end
            end
            S_RUN: begin
                busy_o = 1'b1;
                g_en_o = 1'b1;
                if (g_done_i) w_next = S_WRITE;
            end
            S_WRITE: begin
                busy_o    = 1'b1;
                wr_en_o   = 1'b1;
                wr_addr_o = w_wr_addr;
                wr_data_o = r_result;
                w_next    = S_NEXT;
            end
            S_NEXT: begin
                busy_o = 1'b1;
                w_next = (w_last_x && w_last_y) ? S_FIN : S_FETCH;
            end
            S_FIN: begin
                busy_o       = 1'b1;
                frame_done_o = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (rst_i_g) begin
            busy_o       = 1'b0;
            frame_done_o = 1'b0;
            rd_en_o      = 1'b0;
            rd_addr_o    = '0;
            g_en_o       = 1'b0;
            g_win_o      = '0;
            wr_en_o      = 1'b0;
            wr_addr_o    = '0;
            wr_data_o    = '0;
        end
    end

    // Datapath: pixel coordinates, fetch counter, window and result capture.
    always_ff @(posedge clk_i_g) begin
        if (rst_i_g) begin
            r_x      <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_win    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_cnt <= '0;
                S_FETCH: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_bypass) begin
                        if (r_cnt == 4'd1) r_result <= rd_data_i;
                    end else begin
                        // Data for read k arrives one cycle later (r_cnt == k+1).
                        for (int k = 0; k < 9; k++) begin
                            if (r_cnt == 4'(k + 1)) r_win[8*k +: 8] <= rd_data_i;
                        end
                    end
                end
                S_RUN: begin
                    if (g_done_i) r_result <= g_data_i;
                end
                S_NEXT: begin
                    r_cnt <= '0;
                    if (w_last_x) begin
                        r_x <= '0;
                        r_y <= w_last_y ? '0 : r_y + YW'(1);
                    end else begin
                        r_x <= r_x + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
